// File: rtl/shift_seq_ctrl.sv
// -----------------------------------------------------------------------------
// shift_seq_ctrl
//
// Purpose:
//   Sequencing controller feeding a serial shift chain. A parallel word is
//   accepted through a valid/ready handshake and then shifted out one bit at
//   a time. Each bit is held on ser_out for CLK_DIV cycles, and ser_strb
//   marks the first cycle of every bit. A one-cycle done pulse follows the
//   last bit, and busy covers the whole time a word is in flight.
//
// Parameters:
//   DATA_W  : parallel word width in bits (>= 2)
//   CLK_DIV : sys_clk cycles per serial bit (>= 1)
//
// Optional feature macro:
//   SHIFT_LSB_FIRST_EN : when defined, bits leave LSB first (the register
//                        shifts right). When undefined, bits leave MSB first.
//                        Timing is the same in both builds.
//
// Ports:
//   sys_clk   in   system clock, rising edge
//   sys_rst_n in   asynchronous active-low reset
//   in_valid  in   producer presents a word on in_data
//   in_data   in   [DATA_W-1:0] word to serialise
//   in_ready  out  controller accepts a word (IDLE only)
//   ser_out   out  current serial bit
//   ser_strb  out  one-cycle pulse on the first cycle of each bit
//   busy      out  a word is in flight (SHIFT or DONE)
//   done      out  one-cycle pulse after the last bit completes
// -----------------------------------------------------------------------------
module shift_seq_ctrl #(
    parameter int DATA_W  = 8,
    parameter int CLK_DIV = 4
) (
    input  logic              sys_clk,
    input  logic              sys_rst_n,
    input  logic              in_valid,
    input  logic [DATA_W-1:0] in_data,
    output logic              in_ready,
    output logic              ser_out,
    output logic              ser_strb,
    output logic              busy,
    output logic              done
);

    localparam int DIV_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam int BIT_W = (DATA_W > 1) ? $clog2(DATA_W) : 1;

    // Terminal counts; both counters compare against these instead of
    // relying on natural wrap, so non-power-of-two settings work.
    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);
    localparam logic [BIT_W-1:0] BIT_LAST = BIT_W'(DATA_W - 1);
    localparam logic [DIV_W-1:0] DIV_ONE  = DIV_W'(1);
    localparam logic [BIT_W-1:0] BIT_ONE  = BIT_W'(1);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SHIFT = 2'd1,
        ST_DONE  = 2'd2
    } state_t;

    state_t              state_r;
    logic [DATA_W-1:0]   shreg_r;
    logic [BIT_W-1:0]    bit_cnt_r;
    logic [DIV_W-1:0]    div_cnt_r;

    logic                in_ready_r;
    logic                ser_out_r;
    logic                ser_strb_r;
    logic                busy_r;
    logic                done_r;

    state_t              state_nx_s;
    logic [DATA_W-1:0]   shreg_nx_s;
    logic [BIT_W-1:0]    bit_cnt_nx_s;
    logic [DIV_W-1:0]    div_cnt_nx_s;
    logic                head_bit_nx_s;

    // Next-state computation for the sequencer (state, shift register, counters).
    always_comb begin
        state_nx_s   = state_r;
        shreg_nx_s   = shreg_r;
        bit_cnt_nx_s = bit_cnt_r;
        div_cnt_nx_s = div_cnt_r;
        case (state_r)
            ST_IDLE: begin
                if (in_valid) begin
                    state_nx_s   = ST_SHIFT;
                    shreg_nx_s   = in_data;
                    bit_cnt_nx_s = {BIT_W{1'b0}};
                    div_cnt_nx_s = {DIV_W{1'b0}};
                end else begin
                    state_nx_s   = ST_IDLE;
                end
            end
            ST_SHIFT: begin
                if (div_cnt_r == DIV_LAST) begin
                    div_cnt_nx_s = {DIV_W{1'b0}};
                    if (bit_cnt_r == BIT_LAST) begin
                        state_nx_s = ST_DONE;
                    end else begin
                        bit_cnt_nx_s = bit_cnt_r + BIT_ONE;
`ifdef SHIFT_LSB_FIRST_EN
                        shreg_nx_s   = {1'b0, shreg_r[DATA_W-1:1]};
`else
                        shreg_nx_s   = {shreg_r[DATA_W-2:0], 1'b0};
`endif
                    end
                end else begin
                    div_cnt_nx_s = div_cnt_r + DIV_ONE;
                end
            end
            ST_DONE: begin
                state_nx_s = ST_IDLE;
            end
            default: begin
                state_nx_s = ST_IDLE;
            end
        endcase
    end

    // Bit presented on the serial line once the next state is reached.
    always_comb begin
`ifdef SHIFT_LSB_FIRST_EN
        head_bit_nx_s = shreg_nx_s[0];
`else
        head_bit_nx_s = shreg_nx_s[DATA_W-1];
`endif
    end

    // Sequencer state plus outputs registered from the next-state values, so
    // each output flop matches what the state registers hold in that cycle.
    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            state_r    <= ST_IDLE;
            shreg_r    <= {DATA_W{1'b0}};
            bit_cnt_r  <= {BIT_W{1'b0}};
            div_cnt_r  <= {DIV_W{1'b0}};
            in_ready_r <= 1'b1;
            ser_out_r  <= 1'b0;
            ser_strb_r <= 1'b0;
            busy_r     <= 1'b0;
            done_r     <= 1'b0;
        end else begin
            state_r    <= state_nx_s;
            shreg_r    <= shreg_nx_s;
            bit_cnt_r  <= bit_cnt_nx_s;
            div_cnt_r  <= div_cnt_nx_s;
            in_ready_r <= (state_nx_s == ST_IDLE);
            ser_out_r  <= (state_nx_s == ST_SHIFT) ? head_bit_nx_s : 1'b0;
            ser_strb_r <= (state_nx_s == ST_SHIFT) && (div_cnt_nx_s == {DIV_W{1'b0}});
            busy_r     <= (state_nx_s != ST_IDLE);
            done_r     <= (state_nx_s == ST_DONE);
        end
    end

    assign in_ready = in_ready_r;
    assign ser_out  = ser_out_r;
    assign ser_strb = ser_strb_r;
    assign busy     = busy_r;
    assign done     = done_r;

endmodule

// File: tb/tb_shift_seq_ctrl.sv
// -----------------------------------------------------------------------------
// tb_shift_seq_ctrl
//
// Directed bench for shift_seq_ctrl. Instance dut uses DATA_W=8, CLK_DIV=4;
// instance dut1 uses DATA_W=8, CLK_DIV=1. Outputs are sampled 1 time unit
// after each rising edge and packed as {in_ready, ser_out, ser_strb, busy,
// done}. Cycle n after an accept edge E0 is the period following edge E0+n-1.
// -----------------------------------------------------------------------------
module tb_shift_seq_ctrl;

    logic       sys_clk = 1'b0;
    logic       sys_rst_n;
    logic       in_valid;
    logic [7:0] in_data;
    logic       in_ready, ser_out, ser_strb, busy, done;
    logic       in_valid1;
    logic [7:0] in_data1;
    logic       in_ready1, ser_out1, ser_strb1, busy1, done1;

    int total = 0;
    int bad   = 0;

    always #5 sys_clk = ~sys_clk;

    shift_seq_ctrl #(.DATA_W(8), .CLK_DIV(4)) dut (
        .sys_clk   (sys_clk),
        .sys_rst_n (sys_rst_n),
        .in_valid  (in_valid),
        .in_data   (in_data),
        .in_ready  (in_ready),
        .ser_out   (ser_out),
        .ser_strb  (ser_strb),
        .busy      (busy),
        .done      (done)
    );

    shift_seq_ctrl #(.DATA_W(8), .CLK_DIV(1)) dut1 (
        .sys_clk   (sys_clk),
        .sys_rst_n (sys_rst_n),
        .in_valid  (in_valid1),
        .in_data   (in_data1),
        .in_ready  (in_ready1),
        .ser_out   (ser_out1),
        .ser_strb  (ser_strb1),
        .busy      (busy1),
        .done      (done1)
    );

    task automatic tick();
        @(posedge sys_clk);
        #1;
    endtask

    // k-th transmitted bit of word w (k = 0 is the first bit on the line).
    function automatic logic exp_bit(input logic [7:0] w, input int k);
`ifdef SHIFT_LSB_FIRST_EN
        return w[k];
`else
        return w[7-k];
`endif
    endfunction

    task automatic test_reset();
        logic [4:0] got;
        sys_rst_n = 1'b0;
        for (int i = 0; i < 4; i++) begin
            in_valid  = 1'($urandom);
            in_data   = 8'($urandom);
            in_valid1 = 1'($urandom);
            in_data1  = 8'($urandom);
            tick();
            got = {in_ready, ser_out, ser_strb, busy, done};
            total++;
            if (got !== 5'b10000) begin
                bad++;
                $display("FAIL reset_hold i=%0d got=%b want=%b", i, got, 5'b10000);
            end
            got = {in_ready1, ser_out1, ser_strb1, busy1, done1};
            total++;
            if (got !== 5'b10000) begin
                bad++;
                $display("FAIL reset_hold_div1 i=%0d got=%b want=%b", i, got, 5'b10000);
            end
        end
        in_valid  = 1'b0;
        in_valid1 = 1'b0;
        sys_rst_n = 1'b1;
        tick();
        got = {in_ready, ser_out, ser_strb, busy, done};
        total++;
        if (got !== 5'b10000) begin
            bad++;
            $display("FAIL reset_release got=%b want=%b", got, 5'b10000);
        end
    endtask

    task automatic test_single_word(input logic [7:0] w);
        logic [4:0] got, want;
        in_valid = 1'b1;
        in_data  = w;
        tick();
        in_valid = 1'b0;
        in_data  = 8'h00;
        for (int n = 1; n <= 34; n++) begin
            if (n <= 32)      want = {1'b0, exp_bit(w, (n-1)/4), ((n-1)%4 == 0), 1'b1, 1'b0};
            else if (n == 33) want = 5'b00011;
            else              want = 5'b10000;
            got = {in_ready, ser_out, ser_strb, busy, done};
            total++;
            if (got !== want) begin
                bad++;
                $display("FAIL single_word w=%h n=%0d got=%b want=%b", w, n, got, want);
            end
            if (n < 34) tick();
        end
    endtask

    task automatic test_back_to_back();
        logic [4:0] got, want;
        logic [7:0] w;
        in_valid = 1'b1;
        in_data  = 8'h81;
        tick();
        in_data  = 8'hFF;
        for (int word = 0; word < 2; word++) begin
            w = (word == 0) ? 8'h81 : 8'hFF;
            for (int n = 1; n <= 34; n++) begin
                if (n <= 32)      want = {1'b0, exp_bit(w, (n-1)/4), ((n-1)%4 == 0), 1'b1, 1'b0};
                else if (n == 33) want = 5'b00011;
                else              want = 5'b10000;
                got = {in_ready, ser_out, ser_strb, busy, done};
                total++;
                if (got !== want) begin
                    bad++;
                    $display("FAIL back_to_back word=%0d n=%0d got=%b want=%b", word, n, got, want);
                end
                if (word == 0 || n < 34) tick();
                if (word == 1 && n == 1) in_valid = 1'b0;
            end
            if (word == 0) in_valid = 1'b0;
        end
    endtask

    task automatic test_ignored_busy();
        logic [4:0] got, want;
        in_valid = 1'b1;
        in_data  = 8'h3C;
        tick();
        in_valid = 1'b0;
        for (int n = 1; n <= 34; n++) begin
            if (n == 5) begin
                in_valid = 1'b1;
                in_data  = 8'h00;
            end
            if (n == 33) in_valid = 1'b0;
            if (n <= 32)      want = {1'b0, exp_bit(8'h3C, (n-1)/4), ((n-1)%4 == 0), 1'b1, 1'b0};
            else if (n == 33) want = 5'b00011;
            else              want = 5'b10000;
            got = {in_ready, ser_out, ser_strb, busy, done};
            total++;
            if (got !== want) begin
                bad++;
                $display("FAIL ignored_busy n=%0d got=%b want=%b", n, got, want);
            end
            if (n < 34) tick();
        end
    endtask

    task automatic test_reset_mid_word();
        logic [4:0] got, want;
        in_valid = 1'b1;
        in_data  = 8'hC3;
        tick();
        in_valid = 1'b0;
        for (int n = 1; n <= 13; n++) begin
            want = {1'b0, exp_bit(8'hC3, (n-1)/4), ((n-1)%4 == 0), 1'b1, 1'b0};
            got  = {in_ready, ser_out, ser_strb, busy, done};
            total++;
            if (got !== want) begin
                bad++;
                $display("FAIL mid_word_pre n=%0d got=%b want=%b", n, got, want);
            end
            if (n < 13) tick();
        end
        // Now on the first cycle of bit index 3: reset without waiting for an edge.
        sys_rst_n = 1'b0;
        #1;
        got = {in_ready, ser_out, ser_strb, busy, done};
        total++;
        if (got !== 5'b10000) begin
            bad++;
            $display("FAIL mid_word_async got=%b want=%b", got, 5'b10000);
        end
        tick();
        sys_rst_n = 1'b1;
        for (int n = 0; n < 40; n++) begin
            tick();
            got = {in_ready, ser_out, ser_strb, busy, done};
            total++;
            if (got !== 5'b10000) begin
                bad++;
                $display("FAIL mid_word_no_done n=%0d got=%b want=%b", n, got, 5'b10000);
            end
        end
        in_valid = 1'b1;
        in_data  = 8'h5A;
        tick();
        in_valid = 1'b0;
        for (int n = 1; n <= 34; n++) begin
            if (n <= 32)      want = {1'b0, exp_bit(8'h5A, (n-1)/4), ((n-1)%4 == 0), 1'b1, 1'b0};
            else if (n == 33) want = 5'b00011;
            else              want = 5'b10000;
            got = {in_ready, ser_out, ser_strb, busy, done};
            total++;
            if (got !== want) begin
                bad++;
                $display("FAIL mid_word_next n=%0d got=%b want=%b", n, got, want);
            end
            if (n < 34) tick();
        end
    endtask

    task automatic test_clk_div1();
        logic [4:0] got, want;
        in_valid1 = 1'b1;
        in_data1  = 8'h96;
        tick();
        in_valid1 = 1'b0;
        for (int n = 1; n <= 10; n++) begin
            if (n <= 8)      want = {1'b0, exp_bit(8'h96, n-1), 1'b1, 1'b1, 1'b0};
            else if (n == 9) want = 5'b00011;
            else             want = 5'b10000;
            got = {in_ready1, ser_out1, ser_strb1, busy1, done1};
            total++;
            if (got !== want) begin
                bad++;
                $display("FAIL clk_div1 n=%0d got=%b want=%b", n, got, want);
            end
            if (n < 10) tick();
        end
    endtask

    initial begin
        sys_rst_n = 1'b0;
        in_valid  = 1'b0;
        in_data   = 8'h00;
        in_valid1 = 1'b0;
        in_data1  = 8'h00;
        test_reset();
        tick();
        test_single_word(8'hA5);
        tick();
        test_single_word(8'h0F);
        tick();
        test_back_to_back();
        tick();
        test_ignored_busy();
        tick();
        test_reset_mid_word();
        tick();
        test_clk_div1();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/shift_seq_ctrl.md
Name: shift_seq_ctrl

Overview:
- Sequencing controller that feeds a serial shift chain.
- Accepts one parallel word per valid/ready handshake, then shifts it out one bit at a time.
- Each bit is held for a programmable number of clock cycles, and a strobe marks the start of each bit.
- Sits between a parallel producer (register/FIFO) and downstream serial shift registers or a serial pin, and reports busy/done to the system.

Parameters:
- DATA_W, 8: width of the parallel word, in bits; legal range ≥2.
- CLK_DIV, 4: number of sys_clk cycles each bit is held on ser_out; legal range ≥1.

Ports:
- sys_clk  input  1  system clock; all logic on the rising edge.
- sys_rst_n  input  1  asynchronous, active-low reset.
- in_valid  input  1  producer has a word on in_data.
- in_data  input  DATA_W  parallel word to serialise.
- in_ready  output  1  controller can accept a word (high only in IDLE).
- ser_out  output  1  current serial bit.
- ser_strb  output  1  one-cycle pulse on the first cycle of each bit.
- busy  output  1  high while a word is in flight (SHIFT or DONE).
- done  output  1  one-cycle pulse after the last bit finishes.

Behaviour:
- Clocking and reset: one clock, sys_clk. Reset sys_rst_n is asynchronous and active-low.
- Reset values: state=IDLE, shift register=0, bit_cnt=0, div_cnt=0.
- Outputs at reset: in_ready=1, ser_out=0, ser_strb=0, busy=0, done=0.
- Output timing: all outputs are decoded from registers only. There is no combinational path from in_valid or in_data to any output.
- Counter widths: div_cnt is max(1,$clog2(CLK_DIV)) bits; bit_cnt is max(1,$clog2(DATA_W)) bits. Both counters compare against their terminal value, so there is no reliance on natural wrap.
- State IDLE:
  - in_ready=1, ser_out=0.
  - On a rising edge with in_valid=1: load in_data into the shift register, clear bit_cnt and div_cnt, go to SHIFT.
  - in_data is ignored when in_valid=0.
- State SHIFT:
  - ser_out = shreg[DATA_W-1] (MSB first).
  - ser_strb = (div_cnt==0).
  - div_cnt increments every cycle.
  - When div_cnt==CLK_DIV-1 and bit_cnt<DATA_W-1: shift left by one (zero fill), bit_cnt+1, div_cnt=0.
  - When div_cnt==CLK_DIV-1 and bit_cnt==DATA_W-1: go to DONE.
- State DONE:
  - Lasts one cycle; done=1, ser_out=0, in_ready=0.
  - Always returns to IDLE.
- Latency: with the word accepted at edge E0, SHIFT occupies the DATA_W*CLK_DIV cycles after E0, DONE is the following cycle, and in_ready=1 from the cycle after that.
  - Minimum word-to-word period is DATA_W*CLK_DIV+2 cycles.
- busy = (state!=IDLE).
- in_valid while not IDLE: ignored. The producer must hold in_valid and in_data until the cycle in which in_ready=1.
- CLK_DIV=1: ser_strb is high every SHIFT cycle, and each bit lasts one cycle.
- Reset mid-operation: state returns immediately to IDLE. The word in flight is discarded, and done is not issued.
- in_valid asserted in the same cycle as DONE: not accepted. It is accepted on the next IDLE cycle.

Optional Feature:
- Macro: SHIFT_LSB_FIRST_EN.
- Defined: ser_out = shreg[0], the register shifts right with zero fill, and bits are sent LSB first. Timing is identical.
- Undefined: MSB first, as described in Behaviour.

Test Plan:
1. Reset check: assert sys_rst_n=0 with random inputs -> in_ready=1, ser_out=0, ser_strb=0, busy=0, done=0, both during and right after release.
2. Single word: DATA_W=8, CLK_DIV=4, in_data=8'hA5 pulsed for one cycle -> ser_out carries 1,0,1,0,0,1,0,1 (MSB first), each held 4 cycles.
   - 8 ser_strb pulses, 4 cycles apart.
   - busy high for 33 cycles; done pulses on cycle 33 after accept; in_ready returns high on cycle 34.
   - With SHIFT_LSB_FIRST_EN: order is 1,0,1,0,0,1,0,1 reversed (A5 is symmetric), so use 8'h0F instead -> 1,1,1,1,0,0,0,0.
3. Back-to-back words: in_valid held high with 8'h81 then 8'hFF -> second word accepted exactly 34 cycles after the first; no bit lost or duplicated; in_ready low throughout.
4. Ignored input while busy: change in_data to 8'h00 mid-SHIFT with in_valid=1 -> serial stream still equals the original word; no early accept.
5. Reset mid-word: assert reset at bit 3 of 8'hC3 -> ser_out=0 and state IDLE immediately; no done pulse; the next word serialises correctly from bit 7.
6. CLK_DIV=1: word 8'h96 -> 8 consecutive bits 1,0,0,1,0,1,1,0 with ser_strb high for all 8 cycles; done on cycle 9.
